// File: rtl/arp_req_sched.sv
// ---------------------------------------------------------------------------
// arp_req_sched
//   ARP transmit scheduler. It debounces the user key and turns an accepted
//   press into an ARP request. A request is retried on reply timeout up to
//   MAX_RETRY times. Received ARP requests are answered with replies, and
//   replies take priority over requests. Only one frame is in flight at a
//   time: a new frame starts only after the previous one's arp_tx_done.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   touch_key     : raw asynchronous key (synchronised and debounced here)
//   arp_rx_done   : pulse, ARP frame received; arp_rx_type 0=req 1=reply
//   arp_tx_done   : pulse, transmit module finished the current frame
//   arp_tx_en     : pulse, start a transmission of type arp_tx_type
//   arp_tx_type   : 0=request 1=reply, held for the whole frame
//   arp_resolved  : pulse, reply seen for the outstanding request
//   arp_req_fail  : pulse, retries exhausted without a reply
//   arp_busy      : a request is pending or awaiting its reply
//   retry_cnt     : retransmissions made for the current request
// ---------------------------------------------------------------------------
module arp_req_sched #(
  parameter int SYNC_STAGES  = 3,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 125000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch_key,
  input  logic       arp_rx_done,
  input  logic       arp_rx_type,
  input  logic       arp_tx_done,
  output logic       arp_tx_en,
  output logic       arp_tx_type,
  output logic       arp_resolved,
  output logic       arp_req_fail,
  output logic       arp_busy,
  output logic [7:0] retry_cnt
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [1:0] {R_IDLE, R_PEND, R_WAIT} rq_state_t;
  typedef enum logic       {T_IDLE, T_BUSY}         tx_state_t;

  // Key synchroniser and debouncer
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;
  logic                   key_stable_q;
  logic [DBW-1:0]         deb_cnt_q;
  logic                   key_trig_q;

  // Request tracker
  rq_state_t      rq_q;
  logic [TW-1:0]  timer_q;
  logic [7:0]     retry_q;
  logic           resolved_q;
  logic           fail_q;

  // Transmit arbiter
  tx_state_t      tx_q;
  logic           tx_en_q;
  logic           tx_type_q;
  logic           rpl_pend_q;

  logic           rx_req;
  logic           rx_rpl;
  logic           req_done;

  assign key_s    = sync_q[SYNC_STAGES-1];
  assign rx_req   = arp_rx_done && !arp_rx_type;
  assign rx_rpl   = arp_rx_done &&  arp_rx_type;
  // Only a completed request frame advances the tracker; a finished reply
  // frame must leave the reply timer alone.
  assign req_done = arp_tx_done && (tx_q == T_BUSY) && !tx_type_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], touch_key};
    end
  end

  // deb_cnt_q counts consecutive cycles the synchronised key has differed
  // from the accepted level; any return to the old level restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_stable_q <= 1'b0;
      deb_cnt_q    <= '0;
      key_trig_q   <= 1'b0;
    end else begin
      key_trig_q <= 1'b0;
      if (key_s == key_stable_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        key_stable_q <= key_s;
        deb_cnt_q    <= '0;
        key_trig_q   <= key_s;
      end else begin
        deb_cnt_q <= deb_cnt_q + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_q       <= R_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      resolved_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      resolved_q <= 1'b0;
      fail_q     <= 1'b0;
      case (rq_q)
        R_IDLE: begin
          if (key_trig_q) begin
            rq_q    <= R_PEND;
            retry_q <= '0;
          end
        end
        R_PEND: begin
          if (req_done) begin
            rq_q    <= R_WAIT;
            timer_q <= '0;
          end
        end
        R_WAIT: begin
          // A reply arriving on the timeout cycle still resolves.
          if (rx_rpl) begin
            resolved_q <= 1'b1;
            retry_q    <= '0;
            rq_q       <= R_IDLE;
          end else if (timer_q == TMO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + 8'd1;
              rq_q    <= R_PEND;
            end else begin
              fail_q  <= 1'b1;
              retry_q <= '0;
              rq_q    <= R_IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: rq_q <= R_IDLE;
      endcase
    end
  end

  // Reply requests collapse into one pending flag. The flag is dropped on
  // the edge that launches the reply, so a request landing on that same
  // edge is covered by the reply already going out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= T_IDLE;
      tx_en_q    <= 1'b0;
      tx_type_q  <= 1'b0;
      rpl_pend_q <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      if (rx_req) begin
        rpl_pend_q <= 1'b1;
      end
      case (tx_q)
        T_IDLE: begin
          if (rpl_pend_q) begin
            tx_en_q    <= 1'b1;
            tx_type_q  <= 1'b1;
            tx_q       <= T_BUSY;
            rpl_pend_q <= 1'b0;
          end else if (rq_q == R_PEND) begin
            tx_en_q   <= 1'b1;
            tx_type_q <= 1'b0;
            tx_q      <= T_BUSY;
          end
        end
        T_BUSY: begin
          if (arp_tx_done) begin
            tx_q <= T_IDLE;
          end
        end
        default: tx_q <= T_IDLE;
      endcase
    end
  end

  assign arp_tx_en    = tx_en_q;
  assign arp_tx_type  = tx_type_q;
  assign arp_resolved = resolved_q;
  assign arp_req_fail = fail_q;
  assign arp_busy     = (rq_q != R_IDLE);
  assign retry_cnt    = retry_q;

endmodule

// File: doc/arp_req_sched.md
Name: arp_req_sched

Overview:
Parametrised ARP transmit scheduler for the Ethernet datapath, sitting between user controls/arp_rx and the ARP transmit module. It debounces the user request key, issues ARP requests with timeout and bounded retry, and answers received ARP requests with replies. Replies take priority over requests. A tx_done handshake ensures only one frame is in flight at a time.

Parameters:
SYNC_STAGES, 3, touch_key synchroniser depth (>=2)
DEBOUNCE_CYC, 16, cycles the synchronised key must hold a level before it is accepted (>=1)
TIMEOUT_CYC, 125000000, cycles to wait for an ARP reply after request transmission completes (>=2)
MAX_RETRY, 3, retransmissions allowed after the first request (0..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
touch_key  in  1  raw asynchronous key input; debounced rising edge triggers a request
arp_rx_done  in  1  one-cycle pulse: ARP frame received
arp_rx_type  in  1  received frame type, valid with arp_rx_done: 0 request, 1 reply
arp_tx_done  in  1  one-cycle pulse: ARP tx module finished the current frame
arp_tx_en  out  1  one-cycle pulse: start ARP transmission
arp_tx_type  out  1  frame type to send: 0 request, 1 reply; valid from arp_tx_en until arp_tx_done
arp_resolved  out  1  one-cycle pulse: reply received for the outstanding request
arp_req_fail  out  1  one-cycle pulse: retries exhausted without a reply
arp_busy  out  1  high while a request is pending or awaiting a reply
retry_cnt  out  8  retransmissions made for the current request

Behaviour:
- Reset (async, rst=1): all outputs 0; all FSMs idle; counters and pending flags cleared. Reset mid-operation abandons any frame/request; no pulses are emitted.
- Key path: SYNC_STAGES flops (reset 0), then debounce. A level change is accepted after DEBOUNCE_CYC consecutive cycles of the new level. An accepted 0->1 gives a one-cycle key_trig. Shorter glitches are ignored.
- Reply pending flag (rpl_pend): set on arp_rx_done & arp_rx_type==0. Multiple set events before service collapse into one reply. Cleared in the cycle its arp_tx_en is issued.
- Request tracker states:
  - R_IDLE -> R_PEND on key_trig; retry_cnt <= 0.
  - R_PEND -> R_WAIT on arp_tx_done for a request frame; timer <= 0.
  - R_WAIT: timer increments each cycle.
    - arp_rx_done & type==1 -> arp_resolved pulse, retry_cnt <= 0, R_IDLE.
    - Else, at timer == TIMEOUT_CYC-1:
      - if retry_cnt < MAX_RETRY: retry_cnt+1, R_PEND.
      - else: arp_req_fail pulse, retry_cnt <= 0, R_IDLE.
  - key_trig outside R_IDLE: ignored.
  - Reply received outside R_WAIT: no arp_resolved.
  - Reply and timeout in the same cycle: the reply wins.
- arp_busy = (tracker != R_IDLE).
- Tx arbiter states:
  - T_IDLE: if rpl_pend -> arp_tx_en=1, arp_tx_type<=1, T_BUSY. Else if tracker==R_PEND -> arp_tx_en=1, arp_tx_type<=0, T_BUSY.
  - T_BUSY: holds arp_tx_type; on arp_tx_done -> T_IDLE.
  - The next arp_tx_en is issued no earlier than the cycle after arp_tx_done, so back-to-back frames have a gap of 1 cycle.
- Replies may preempt between request retransmissions. The R_WAIT timer keeps running while a reply frame is sent.
- Registered outputs: arp_tx_en is asserted the cycle after the arbitration condition is sampled. arp_resolved and arp_req_fail are asserted the cycle after their trigger.
- arp_tx_done in T_IDLE: ignored.
- Timer width = clog2(TIMEOUT_CYC); no wrap occurs before timeout.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, TIMEOUT_CYC=100, MAX_RETRY=2.
1. Key high with 2-cycle glitches, then held 10 cycles -> exactly one arp_tx_en with type 0; no tx_en from the glitches; arp_busy=1.
2. Request sent, tx_done given, reply (rx_done, type 1) at timer=50 -> arp_resolved 1 cycle later; arp_busy=0; retry_cnt=0; no further tx_en.
3. Request with no reply -> 3 request tx_en total, spaced 100 cycles after each tx_done; retry_cnt goes 1 then 2; arp_req_fail pulses 100 cycles after the third tx_done.
4. Three rx requests (type 0) during a busy request frame -> after tx_done, a single reply tx_en with type 1; arp_tx_type holds 1 until its tx_done.
5. rx request and key_trig arriving together in T_IDLE -> reply is sent first, then the request on the cycle after the reply's tx_done.
6. rst pulsed during R_WAIT -> all outputs 0 immediately; no arp_req_fail afterwards; a new key press restarts with retry_cnt=0.
